bcd_stream_decoder: RTL
=======================

BCD_STREAM_DECODER -- requirements
Module: bcd_stream_decoder

Interface
REQ-001 Parameter ERR_CNT_W, default 8, width of the saturating invalid-code counter.
REQ-002 i_clk  input  1  sole clock, rising-edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_en  input  1  decode enable, sampled with each accepted input beat.
REQ-005 i_valid  input  1  input beat present.
REQ-006 o_ready  output  1  block can accept an input beat.
REQ-007 i_bcd  input  4  BCD digit code.
REQ-008 o_valid  output  1  output beat present.
REQ-009 i_ready  input  1  downstream accepts the output beat.
REQ-010 o_y  output  10  one-hot decoded digit; bit n set for digit n.
REQ-011 o_err  output  1  current output beat carried an invalid code (10-15).
REQ-012 o_err_cnt  output  ERR_CNT_W  count of accepted invalid codes, saturating.
REQ-013 i_clr_cnt  input  1  synchronous clear of o_err_cnt.

Function
REQ-014 An input beat is accepted on a rising edge with i_valid=1 and o_ready=1; an output beat is consumed on a rising edge with o_valid=1 and i_ready=1.
REQ-015 Decode happens at acceptance; each accepted beat is stored as an 11-bit entry {err, y}.
REQ-016 Decode with i_en=1: code 0-9 -> y has exactly bit[code] set, err=0; code 10-15 -> y=0, err=1.
REQ-017 Decode with i_en=0: y=0, err=0 for any code; the beat still passes through and counts as a beat.
REQ-018 Storage is a 2-entry FIFO; occupancy FSM states EMPTY, ONE, FULL.
REQ-019 Transitions: EMPTY+push -> ONE; ONE+push only -> FULL; ONE+pop only -> EMPTY; ONE+push+pop -> ONE; FULL+pop -> ONE; all other cases hold state.
REQ-020 o_ready = 1 in EMPTY and ONE, 0 in FULL; o_ready depends only on registered state (no combinational path from i_ready or i_valid).
REQ-021 No push occurs in FULL, even if a pop occurs in the same cycle.
REQ-022 o_valid = 1 in ONE and FULL; o_y/o_err present the head entry; o_valid, o_y and o_err are 0 in EMPTY.
REQ-023 Latency: a beat accepted into EMPTY at edge N appears on o_valid/o_y/o_err after edge N.
REQ-024 Output stability: while o_valid=1 and i_ready=0, o_y and o_err remain unchanged.
REQ-025 Ordering: beats leave in acceptance order; none is dropped or duplicated.
REQ-026 o_err_cnt increments by 1 at each accepted beat with i_en=1 and i_bcd in 10-15.
REQ-027 o_err_cnt saturates at 2^ERR_CNT_W-1 and does not wrap.
REQ-028 i_clr_cnt=1 sets o_err_cnt to 0 at the next edge and takes priority over a simultaneous increment.
REQ-029 Counter updates on acceptance, independent of output consumption or back-pressure.

Reset
REQ-030 While i_rst=1: FSM=EMPTY, o_valid=0, o_y=0, o_err=0, o_err_cnt=0, o_ready=0.
REQ-031 o_ready rises to 1 on the first rising edge after i_rst deasserts.
REQ-032 Reset asserted mid-operation discards all stored entries immediately, regardless of clock.

Structure
REQ-033 Shared package bcd_pkg holds BCD_W=4, ONEHOT_W=10, BCD_MAX=9 and the occupancy state enum (EMPTY, ONE, FULL).
REQ-034 The 4-to-{err,10} decode is a combinational sub-module bcd_decoder_comb, instantiated once at the input side.

Verification
REQ-035 Sweep: i_en=1, i_ready=1, feed codes 0..9 back-to-back -> o_y = 0000000001 .. 1000000000, one cycle after each input, o_err=0, o_err_cnt=0.
REQ-036 Invalid: i_en=1, codes 10..15 -> six beats with o_y=0, o_err=1; o_err_cnt=6.
REQ-037 Disable: i_en=0, codes 3 and 12 -> two beats with o_y=0, o_err=0; o_err_cnt unchanged.
REQ-038 Back-pressure: i_ready=0, push 5, 7, 9 -> o_ready=0 after the 2nd push, 9 not accepted, o_y holds 0000100000; release i_ready -> 5 then 7 out, then 9 is accepted and output.
REQ-039 Saturation/clear: ERR_CNT_W=2, push five code-15 beats -> o_err_cnt sticks at 3; i_clr_cnt=1 together with a 6th invalid beat -> o_err_cnt=0.
REQ-040 Reset mid-stream: FIFO FULL, assert i_rst between edges -> o_valid=0, o_err_cnt=0 immediately; o_ready=1 one edge after release.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, occupancy state and FIFO entry layout for the BCD stream decoder.
package bcd_pkg;

    localparam int BCD_W    = 4;
    localparam int ONEHOT_W = 10;
    localparam int BCD_MAX  = 9;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic                err;
        logic [ONEHOT_W-1:0] y;
    } entry_t;

endpackage

// File: rtl/bcd_decoder_comb.sv
// Combinational BCD digit to one-hot decode with an invalid-code flag.
module bcd_decoder_comb
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0]    i_bcd,
    input  logic                i_en,
    output logic [ONEHOT_W-1:0] o_y,
    output logic                o_err
);

    // A disabled decode yields an all-zero beat, never an error.
    always_comb begin
        o_y   = '0;
        o_err = 1'b0;
        if (i_en) begin
            if (i_bcd <= BCD_W'(BCD_MAX)) begin
                o_y = ONEHOT_W'(1) << i_bcd;
            end else begin
                o_err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_stream_decoder.sv
// Valid/ready BCD decoder: decodes at acceptance, buffers in a 2-entry FIFO,
// and keeps a saturating count of accepted invalid codes.
module bcd_stream_decoder
    import bcd_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [BCD_W-1:0]     i_bcd,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ONEHOT_W-1:0]  o_y,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    input  logic                 i_clr_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    occ_state_e           state_q, state_d;
    logic                 live_q, live_d;
    entry_t               mem_q [2];
    entry_t               mem_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 push;
    logic                 pop;
    entry_t               dec_entry;
    logic [ONEHOT_W-1:0]  dec_y;
    logic                 dec_err;

    bcd_decoder_comb u_decoder (
        .i_bcd (i_bcd),
        .i_en  (i_en),
        .o_y   (dec_y),
        .o_err (dec_err)
    );

    assign dec_entry = '{err: dec_err, y: dec_y};

    // o_ready is gated off FULL, so a push can never land in a full FIFO.
    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = FULL;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // live_q holds o_ready low until the first edge after reset is released.
    always_comb begin
        o_ready = live_q && (state_q != FULL);
        o_valid = 1'b0;
        o_y     = '0;
        o_err   = 1'b0;
        if (state_q != EMPTY) begin
            o_valid = 1'b1;
            o_y     = mem_q[rd_ptr_q].y;
            o_err   = mem_q[rd_ptr_q].err;
        end
    end

    always_comb begin
        live_d   = 1'b1;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = dec_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (i_clr_cnt) begin
            err_cnt_d = '0;
        end else if (push && dec_err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            live_q    <= 1'b0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            live_q    <= live_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_cnt_q <= err_cnt_d;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign o_err_cnt = err_cnt_q;

endmodule
